// File: rtl/rr_arb_queue_pkg.sv
// Shared constants for rr_arb_queue: reset fill value for queue storage and the
// width of the optional per-channel grant counters (RR_ARB_QUEUE_STATS_EN).
package rr_arb_queue_pkg;

  localparam int   STATS_W = 16;
  localparam logic DC_FILL = 1'b0;

  // Circular-pointer step used by the queue; handles non power-of-2 depths.
  function automatic int wrap_inc(input int cur, input int limit);
    return (cur == limit - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_arb_queue_store.sv
// Circular DEPTH-entry storage for rr_arb_queue. Head word is always mem[rptr],
// so readout is registered with one-cycle write-to-read latency.
module rr_arb_queue_store
  import rr_arb_queue_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push      = we & ~full;
  assign pop       = re & ~empty;
  assign dout      = mem[rptr];
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {W{DC_FILL}};
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= PTR_W'(wrap_inc(int'(wptr), DEPTH));
      end
      if (pop) rptr <= PTR_W'(wrap_inc(int'(rptr), DEPTH));
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rr_arb_queue.sv
// N-to-1 round-robin arbiter feeding a DEPTH-entry output queue with source tags.
// Optional per-channel saturating grant counters under RR_ARB_QUEUE_STATS_EN.
module rr_arb_queue
  import rr_arb_queue_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(NUM_IN),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              valid_us,
  input  logic [NUM_IN-1:0][WIDTH-1:0]   data_us,
  output logic [NUM_IN-1:0]              stall_us,
  output logic                           valid_ds,
  output logic [WIDTH-1:0]               data_ds,
  output logic [IDX_W-1:0]               src_ds,
  input  logic                           stall_ds,
  output logic [CNT_W-1:0]               occupancy
`ifdef RR_ARB_QUEUE_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [NUM_IN-1:0][STATS_W-1:0] grant_cnt
`endif
);

  typedef struct packed {
    logic [IDX_W-1:0] src;
    logic [WIDTH-1:0] data;
  } head_t;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] grant_oh;
  logic              grant_any;
  logic              full;
  logic              empty;
  head_t             din;
  head_t             head;

  // Handshake: a word transfers when valid is high and stall is low in the same
  // cycle; a stalled producer holds valid and data. Grants depend only on the
  // registered full flag, so stall_ds never reaches stall_us combinationally.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    if (!full) begin
      for (int i = 1; i <= NUM_IN; i++) begin
        cand = (int'(ptr) + i) % NUM_IN;
        if (!grant_any && valid_us[cand]) begin
          grant_any      = 1'b1;
          grant_idx      = cand[IDX_W-1:0];
          grant_oh[cand] = 1'b1;
        end
      end
    end
  end

  assign stall_us = valid_us & ~grant_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ptr <= IDX_W'(NUM_IN - 1);
    else if (grant_any) ptr <= grant_idx;
  end

  assign din.src  = grant_idx;
  assign din.data = data_us[grant_idx];

  rr_arb_queue_store #(
    .W     ($bits(head_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .we        (grant_any),
    .re        (stall_ds == 1'b0),
    .din       (din),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  assign valid_ds = ~empty;
  assign data_ds  = head.data;
  assign src_ds   = head.src;

`ifdef RR_ARB_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)
        if (grant_oh[i] && grant_cnt[i] != {STATS_W{1'b1}}) grant_cnt[i] <= grant_cnt[i] + 1'b1;
    end
  end
`endif

endmodule

// File: doc/rr_arb_queue.md
Name: rr_arb_queue

Overview:
- Parametrised N-to-1 round-robin arbiter with a built-in output queue. It is the successor to the fixed 2-deep arbiter.
- Adds a fair last-grant pointer, a configurable queue depth, a source-index tag on every output word, and an occupancy output.
- Sits between several valid/stall producers (ray/shader units) and one valid/stall consumer, such as a memory or cache request port.

Parameters:
- NUM_IN, 4, number of upstream channels (at least 2).
- WIDTH, 32, payload bits per channel.
- DEPTH, 8, output queue entries (at least 2; need not be a power of 2).
- IDX_W, $clog2(NUM_IN), source-tag width (derived; do not override).
- CNT_W, $clog2(DEPTH+1), occupancy width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- valid_us  in  NUM_IN  per-channel request valid.
- data_us  in  NUM_IN x WIDTH  per-channel payload (packed 2-D).
- stall_us  out  NUM_IN  per-channel stall; producer holds data while stalled.
- valid_ds  out  1  queue head valid.
- data_ds  out  WIDTH  queue head payload.
- src_ds  out  IDX_W  channel index that produced the head word.
- stall_ds  in  1  consumer stall; a pop happens when valid_ds & ~stall_ds.
- occupancy  out  CNT_W  entries currently held.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: queue empty, valid_ds=0, occupancy=0, data_ds=0, src_ds=0, last-grant pointer = NUM_IN-1 (channel 0 has first priority).
- Grant selection (combinational, same cycle):
  - If the queue is not full, grant the first asserted valid_us found by searching upward from (ptr+1) mod NUM_IN, wrapping.
  - If the queue is full, grant nothing.
  - At most one grant per cycle.
- stall_us = valid_us & ~grant. An input with valid_us=0 never sees a stall.
- Pointer update: on a grant, ptr <= granted index. With no grant, ptr holds. Consequence: a continuously-valid channel waits at most NUM_IN-1 grants.
- Write on grant:
  - Write {granted index, data_us[granted]} at wptr.
  - wptr wraps from DEPTH-1 to 0.
- Latency: a word granted in cycle N is visible on valid_ds/data_ds/src_ds in cycle N+1, if the queue was empty. There is no combinational bypass.
- Pop:
  - When valid_ds & ~stall_ds, advance rptr with the same wrap rule.
  - data_ds/src_ds always show entry[rptr], registered.
- Full rule:
  - full = (occupancy == DEPTH) gates all grants, even if a pop occurs in the same cycle.
  - There is no combinational path from stall_ds to stall_us.
- Simultaneous push and pop (not full, not empty): occupancy is unchanged and both pointers advance.
- Empty rule: valid_ds=0. A pop attempt with valid_ds=0 is ignored.
- Occupancy: +1 on push only, -1 on pop only, unchanged otherwise. It is never outside 0..DEPTH.
- Reset mid-operation: all queued words are discarded, and the pointer and occupancy return to their reset values immediately (asynchronous).
- Unused data_us lanes are don't-care. data_ds is don't-care when valid_ds=0; the bench must not check it then.

Optional Feature:
- Macro: RR_ARB_QUEUE_STATS_EN.
- Defined:
  - Adds output grant_cnt [NUM_IN x 16], one saturating counter per channel, each incremented on that channel's grant.
  - Adds input stats_clr, which clears all counters synchronously; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: no counter logic, and the grant_cnt/stats_clr ports are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package (COMMON/structs.sv), holds:
  - a parametrisable head-entry struct type {src, data};
  - the DC fill constant, already shared;
  - the stats counter width constant STATS_W=16.
- Sub-module: rr_arb_queue_store, the circular DEPTH-entry storage.
  - Ports: we, re, din, dout, full, empty, occupancy.
  - Built on ff_ar-style asynchronous-reset registers.
  - The arbiter/grant logic stays in the top level.

Test Plan (NUM_IN=4, WIDTH=8, DEPTH=4):
- Fairness: all 4 valid continuously, stall_ds=0 → grants rotate 0,1,2,3,0…; src_ds sequence 0,1,2,3 starting the cycle after the first grant; stall_us shows 3 asserted bits per cycle.
- Skip idle channels: valid_us=4'b1010 held, ptr at reset → grants 1,3,1,3…; stall_us[0] and stall_us[2] stay 0.
- Full with pop: stall_ds=1 and only ch2 valid with data 0xA0..0xA3 → occupancy reaches 4 and stall_us[2]=1. In that cycle, release stall_ds → pop 0xA0; no grant occurs that cycle; the next grant follows one cycle later with occupancy=3→4.
- Empty/latency: single pulse valid_us[1] with data 0x5C into an empty queue → valid_ds=1, data_ds=0x5C, src_ds=1 in the next cycle; with stall_ds=0 the queue is empty again one cycle after that.
- Wrap and order: push 10 words across channels with random stall_ds → output order equals grant order, with no loss and no duplicates; occupancy never exceeds 4.
- Async reset mid-stream: assert rst between clock edges with occupancy=3 → valid_ds=0 and occupancy=0 immediately; after release, first grant goes to channel 0. With RR_ARB_QUEUE_STATS_EN: counters are 0; 70000 grants to ch0 saturate at 0xFFFF; stats_clr returns it to 0.
